// File: rtl/acc_c_slave_adapter.sv
// Accelerator-side C-interface responder: buffers q requests, checks the routed address,
// issues to a single functional unit under response credits and returns in-order p responses.
// Build option: define ACC_C_SLV_WB_FILTER_EN to drop the responses of ops whose rd is x0.

module acc_c_slv_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push,
   input  logic [Width-1:0]           wdata,
   input  logic                       pop,
   output logic [Width-1:0]           rdata,
   output logic [$clog2(Depth+1)-1:0] usage
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned UsgW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (usage != UsgW'(Depth));
   assign do_pop  = pop && (usage != '0);
   assign rdata   = (usage != '0) ? mem[rd_ptr] : '0;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Circular buffer; empty head reads as zero so idle outputs stay quiet
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         usage  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         usage <= usage + UsgW'(do_push) - UsgW'(do_pop);
      end
   end
endmodule

module acc_c_slave_adapter #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 4,
   parameter int unsigned IdWidth   = 5,
   parameter int unsigned AccAddr   = 0,
   parameter int unsigned ReqDepth  = 2,
   parameter int unsigned RspDepth  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   c_q_valid_i,
   output logic                   c_q_ready_o,
   input  logic [AddrWidth-1:0]   c_q_addr_i,
   input  logic [DataWidth-1:0]   c_q_data_arga_i,
   input  logic [DataWidth-1:0]   c_q_data_argb_i,
   input  logic [DataWidth-1:0]   c_q_data_argc_i,
   input  logic [31:0]            c_q_data_op_i,
   input  logic [IdWidth-1:0]     c_q_id_i,
   output logic                   c_p_valid_o,
   input  logic                   c_p_ready_i,
   output logic [DataWidth-1:0]   c_p_data_o,
   output logic [IdWidth-1:0]     c_p_id_o,
   output logic                   c_p_error_o,
   output logic                   acc_req_valid_o,
   input  logic                   acc_req_ready_i,
   output logic [31:0]            acc_req_op_o,
   output logic [3*DataWidth-1:0] acc_req_arg_o,
   input  logic                   acc_rsp_valid_i,
   input  logic [DataWidth-1:0]   acc_rsp_data_i
);
   localparam int unsigned ReqW  = 1 + 32 + 3 * DataWidth + IdWidth;
   localparam int unsigned RspW  = DataWidth + IdWidth + 1;
   localparam int unsigned ReqUW = $clog2(ReqDepth + 1);
   localparam int unsigned CntW  = $clog2(RspDepth + 1);
`ifdef ACC_C_SLV_WB_FILTER_EN
   localparam int unsigned TagW  = IdWidth + 1;
`else
   localparam int unsigned TagW  = IdWidth;
`endif

   logic [ReqW-1:0]        req_wdata;
   logic [ReqW-1:0]        req_rdata;
   logic [ReqUW-1:0]       req_usage;
   logic                   req_push;
   logic                   req_pop;
   logic                   req_valid;
   logic                   head_err;
   logic [31:0]            head_op;
   logic [3*DataWidth-1:0] head_args;
   logic [IdWidth-1:0]     head_id;

   logic [TagW-1:0]        tag_wdata;
   logic [TagW-1:0]        tag_rdata;
   logic [IdWidth-1:0]     tag_id;
   logic [CntW-1:0]        outstanding;

   logic [RspW-1:0]        rsp_wdata;
   logic [RspW-1:0]        rsp_rdata;
   logic [CntW-1:0]        rsp_usage;
   logic                   rsp_push;
   logic                   rsp_pop;
   logic                   rsp_full;

   logic                   credit_ok;
   logic                   issue;
   logic                   err_go;
   logic                   comp;
   logic                   comp_wb;

   // Request side: address check happens once, at acceptance
   assign c_q_ready_o = (req_usage != ReqUW'(ReqDepth));
   assign req_push    = c_q_valid_i && c_q_ready_o;
   assign req_wdata   = {(c_q_addr_i != AddrWidth'(AccAddr)), c_q_data_op_i,
                         c_q_data_argc_i, c_q_data_argb_i, c_q_data_arga_i, c_q_id_i};
   assign req_valid   = (req_usage != '0);
   assign {head_err, head_op, head_args, head_id} = req_rdata;

   acc_c_slv_fifo #(.Width(ReqW), .Depth(ReqDepth)) u_req_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (req_push),
      .wdata  (req_wdata),
      .pop    (req_pop),
      .rdata  (req_rdata),
      .usage  (req_usage)
   );

   // Every in-flight op and every queued response holds one credit
   assign credit_ok       = ((CntW+1)'(outstanding) + (CntW+1)'(rsp_usage)) < (CntW+1)'(RspDepth);
   assign acc_req_valid_o = req_valid && !head_err && credit_ok;
   assign acc_req_op_o    = head_op;
   assign acc_req_arg_o   = head_args;
   assign issue           = acc_req_valid_o && acc_req_ready_i;
   assign rsp_full        = (rsp_usage == CntW'(RspDepth));
   assign err_go          = req_valid && head_err && (outstanding == '0) && !rsp_full;
   assign req_pop         = issue || err_go;

   // Tag FIFO occupancy is the outstanding count
   assign comp   = acc_rsp_valid_i && (outstanding != '0);
   assign tag_id = tag_rdata[IdWidth-1:0];
`ifdef ACC_C_SLV_WB_FILTER_EN
   assign tag_wdata = {(head_op[11:7] == 5'd0), head_id};
   assign comp_wb   = !tag_rdata[IdWidth];
`else
   assign tag_wdata = head_id;
   assign comp_wb   = 1'b1;
`endif

   acc_c_slv_fifo #(.Width(TagW), .Depth(RspDepth)) u_tag_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (issue),
      .wdata  (tag_wdata),
      .pop    (comp),
      .rdata  (tag_rdata),
      .usage  (outstanding)
   );

   // Error and completion pushes are exclusive: errors only leave when nothing is in flight
   assign rsp_push  = err_go || (comp && comp_wb);
   assign rsp_wdata = err_go ? {{DataWidth{1'b0}}, head_id, 1'b1}
                             : {acc_rsp_data_i, tag_id, 1'b0};
   assign c_p_valid_o = (rsp_usage != '0);
   assign rsp_pop     = c_p_valid_o && c_p_ready_i;
   assign {c_p_data_o, c_p_id_o, c_p_error_o} = rsp_rdata;

   acc_c_slv_fifo #(.Width(RspW), .Depth(RspDepth)) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (rsp_push),
      .wdata  (rsp_wdata),
      .pop    (rsp_pop),
      .rdata  (rsp_rdata),
      .usage  (rsp_usage)
   );

`ifndef SYNTHESIS
   a_rsp_without_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      acc_rsp_valid_i |-> (outstanding != '0));
   a_rsp_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rsp_push |-> !rsp_full);
`endif
endmodule
